// File: rtl/match_pkg.sv
// Shared codes and record type for the match event logger.
// No logic; types and a decode helper only.
// No flow control of its own.
package match_pkg;

    typedef logic [1:0] code_t;

    localparam code_t CODE_NONE    = 2'b00;
    localparam code_t CODE_A       = 2'b01;
    localparam code_t CODE_ILLEGAL = 2'b10;
    localparam code_t CODE_B       = 2'b11;

    localparam int REC_TS_W = 16;

    // Record layout at the default timestamp width; the top repacks at its own TS_W.
    typedef struct packed {
        code_t                code;
`ifdef MATCH_LOG_TIMESTAMP_EN
        logic [REC_TS_W-1:0]  ts;
`endif
    } ev_rec_t;

    function automatic logic is_event(code_t c);
        return (c == CODE_A) || (c == CODE_B);
    endfunction

endpackage

// File: rtl/match_fifo.sv
// Synchronous FIFO with wrap-bit pointers and synchronous flush.
// Latency: a push is visible at the head one edge later.
// Backpressure: push is ignored while full, pop is ignored while empty.
module match_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/match_event_logger.sv
// Logs detector hits as {code, timestamp} records; timestamp only with MATCH_LOG_TIMESTAMP_EN.
// Latency: y_in registered at edge k, record pushed and counters/flags updated at edge k+1.
// Backpressure: ev_valid/ev_ready drain; events arriving while full are dropped and flagged.
module match_event_logger
    import match_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TS_W  = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       y_in,
    input  logic             clr,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [1:0]       ev_code,
    output logic [TS_W-1:0]  ev_ts,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic             overflow,
    output logic             illegal
);

`ifdef MATCH_LOG_TIMESTAMP_EN
    localparam int REC_W = 2 + TS_W;
`else
    localparam int REC_W = 2;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    code_t            y_q;
    logic [REC_W-1:0] wr_rec;
    logic [REC_W-1:0] rd_rec;
    logic             fifo_full;
    logic             fifo_empty;
    logic             ev_hit;
    logic             pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   y_q <= CODE_NONE;
        else if (clr) y_q <= CODE_NONE;
        else          y_q <= code_t'(y_in);
    end

`ifdef MATCH_LOG_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_q;

    // ts_q holds the counter value seen at the edge that captured y_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt <= '0;
            ts_q   <= '0;
        end else if (clr) begin
            ts_cnt <= '0;
            ts_q   <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            ts_q   <= ts_cnt;
        end
    end

    assign wr_rec  = {y_q, ts_q};
    assign ev_code = rd_rec[REC_W-1 -: 2];
    assign ev_ts   = rd_rec[TS_W-1:0];
`else
    assign wr_rec  = y_q;
    assign ev_code = rd_rec;
    assign ev_ts   = {TS_W{1'b0}};
`endif

    assign ev_hit   = is_event(y_q) && !clr;
    assign ev_valid = !fifo_empty;
    assign pop      = ev_valid && ev_ready && !clr;

    match_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (clr),
        .push  (ev_hit),
        .wdata (wr_rec),
        .pop   (pop),
        .rdata (rd_rec),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Counters see every event, including ones the full FIFO drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a    <= '0;
            cnt_b    <= '0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
        end else if (clr) begin
            cnt_a    <= '0;
            cnt_b    <= '0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            if (y_q == CODE_A && cnt_a != CNT_MAX) cnt_a <= cnt_a + 1'b1;
            if (y_q == CODE_B && cnt_b != CNT_MAX) cnt_b <= cnt_b + 1'b1;
            if (ev_hit && fifo_full)               overflow <= 1'b1;
            if (y_q == CODE_ILLEGAL)               illegal  <= 1'b1;
        end
    end

endmodule

// File: doc/match_event_logger.md
# match_event_logger

Downstream consumer of the 2-bit Moore sequence-detector code. Samples the detector's `y` every cycle, turns each non-zero code into an event record (code + cycle timestamp), buffers records in a small FIFO drained over a valid/ready handshake, and keeps saturating per-pattern hit counters plus sticky overflow and illegal-code flags for status readout.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `TS_W`, 16: timestamp width.
- `CNT_W`, 8: width of each hit counter.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `y_in`, in, 2: detector code; 00 none, 01 pattern A (10001), 11 pattern B (10101), 10 illegal.
- `clr`, in, 1: synchronous clear of FIFO, counters, flags and timestamp.
- `ev_valid`, out, 1: head record available.
- `ev_ready`, in, 1: consumer accepts head record.
- `ev_code`, out, 2: head record code.
- `ev_ts`, out, TS_W: head record timestamp.
- `cnt_a`, out, CNT_W: pattern-A hits, saturating.
- `cnt_b`, out, CNT_W: pattern-B hits, saturating.
- `overflow`, out, 1: sticky; an event was dropped because the FIFO was full.
- `illegal`, out, 1: sticky; code 10 was sampled.

## Operation
- Input stage: `y_in` is registered every cycle into `y_q`, together with `ts_q`, the timestamp counter value at that edge.
- Event: a cycle in which `y_q` is 01 or 11. Each such cycle produces exactly one event; back-to-back non-zero cycles produce one event each.
- Code 10: sets `illegal` and is not pushed or counted. Code 00: no action.
- Push: writes an event record {`y_q`, `ts_q`} into the FIFO if the FIFO is not full at that edge.
  - If the FIFO is full, the record is dropped and `overflow` is set, even if a pop happens on the same edge.
  - Counters increment for every event, whether it is pushed or dropped.
- Pop: occurs on an edge where `ev_valid && ev_ready`. Pop and push on the same edge are both performed when the FIFO is not full.
- Counters: `cnt_a` increments on code 01 and `cnt_b` on code 11. Both hold at 2^CNT_W−1 and never wrap.
- Timestamp: free-running TS_W counter; +1 every cycle, wraps from 2^TS_W−1 to 0.
- `clr` has priority over everything in the same cycle:
  - empties the FIFO;
  - zeros the counters, `overflow`, `illegal`, the timestamp and `y_q`;
  - discards any event sampled on that edge.
- FIFO outputs: `ev_code`/`ev_ts` come directly from the head entry and are don't-care while `ev_valid`=0. They must stay stable while `ev_valid`=1 and `ev_ready`=0.

## Timing
- Reset values (asynchronous, on `rst_n`=0):
  - `ev_valid`=0, `ev_code`=0, `ev_ts`=0;
  - `cnt_a`=0, `cnt_b`=0, `overflow`=0, `illegal`=0;
  - timestamp=0, `y_q`=00, FIFO empty.
- Reset mid-operation discards all queued records immediately. Deassertion is followed by normal sampling from the next edge.
- Latency: `y_in` non-zero before edge k → `y_q` at k → record written at edge k+1 → `ev_valid`=1 after k+1 if the FIFO was empty. Recorded timestamp = counter value sampled at edge k.
- Counters and flags update at edge k+1, the same edge as the push.
- Throughput: one push and one pop per cycle. A permanently ready consumer never causes overflow.
- `ev_valid` deasserts on the edge that pops the last entry, unless a push occurs on the same edge.

## Configuration
- `MATCH_LOG_TIMESTAMP_EN` defined:
  - timestamp counter present;
  - FIFO entries are 2+TS_W bits;
  - `ev_ts` carries the recorded timestamp.
- Not defined:
  - no timestamp counter;
  - FIFO entries are 2 bits;
  - `ev_ts` is tied to 0;
  - all other behaviour, including latency, is identical.

## Structure
- Package `match_pkg`:
  - code constants `CODE_NONE`=2'b00, `CODE_A`=2'b01, `CODE_ILLEGAL`=2'b10, `CODE_B`=2'b11;
  - the event-record typedef (code, optional timestamp).
- Sub-module `match_fifo`: synchronous FIFO with DEPTH and WIDTH parameters, push/pop/full/empty/flush, and pointers with an extra wrap bit.
- Top level holds the input register, timestamp, counters and flags.

## Test plan
- Reset → all outputs 0. Drive `y_in`=01 for one cycle sampled at edge 10 → `ev_valid` high after edge 11, `ev_code`=01, `ev_ts`=10, `cnt_a`=1.
- `ev_ready`=0, DEPTH=4, six events of code 11 → four records held, `overflow`=1, `cnt_b`=6. Then `ev_ready`=1 → four records drained in order, then `ev_valid`=0.
- FIFO full, a pop and an event on the same edge → event dropped, `overflow`=1, occupancy 3.
- CNT_W=8, 300 code-01 events with the consumer always ready → `cnt_a`=255, `overflow`=0.
- `y_in`=10 → `illegal`=1, no record, counters unchanged. `clr` on the same edge as a code-01 sample → everything 0, no record.
- Timestamp wrap (TS_W=4): events sampled at counter values 15 and then 0 → `ev_ts` 15 then 0. Without the macro → `ev_ts`=0 and records still correct.
